meter_display: RTL and testbench



---
 rtl/meter_display.sv | 143 ++++++++++++++
 tb/tb_meter_display.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/meter_display.sv
// meter_display: BCD conversion, digit multiplexing and blink/blank gating for a 4-digit seven-segment display
module meter_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_HALF  = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic [15:0] times,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] LIM_SLOW = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] LIM_FAST = BW'(BLINK_HALF / 2 - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic          first_q, first_d;
    logic [15:0]   last_q, last_d;
    logic [31:0]   sr_q, sr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   adj;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          phase_q, phase_d;
    logic [1:0]    mode_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    nib;
    logic [6:0]    pat;
    logic          hold, wrap, blank;

    // add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++)
            adj[4*i +: 4] = sr_q[16+4*i +: 4] >= 4'd5 ? sr_q[16+4*i +: 4] + 4'd3 : sr_q[16+4*i +: 4];
    end

    // converter: capture a new value, run 16 shift-add-3 steps, then publish the BCD result
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: if (first_q || times != last_q) begin
                state_d = LOAD;
                first_d = 1'b0;
                last_d  = times;
            end
            LOAD: begin
                sr_d    = {16'd0, last_q > 16'd9999 ? 16'd9999 : last_q};
                cnt_d   = 4'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d    = {adj, sr_q[15:0]} << 1;
                cnt_d   = cnt_q + 4'd1;
                state_d = cnt_q == 4'd15 ? DONE : SHIFT;
            end
            default: begin
                disp_d  = sr_q[31:16];
                state_d = IDLE;
            end
        endcase
    end

    // digit scan, blink phase and registered output gating
    always_comb begin
        ref_d   = ref_q == REF_MAX ? '0 : ref_q + RW'(1);
        idx_d   = ref_q == REF_MAX ? idx_q + 2'd1 : idx_q;
        hold    = mode != mode_q || !mode[1];
        wrap    = blk_q == (mode == 2'b11 ? LIM_SLOW : LIM_FAST);
        blk_d   = hold || wrap ? '0 : blk_q + BW'(1);
        phase_d = hold ? 1'b1 : wrap ? ~phase_q : phase_q;
        blank   = !phase_d || mode == 2'b00;
        nib     = disp_q[{idx_q, 2'b00} +: 4];
        case (nib)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = blank ? 7'b1111111 : pat;
    end

    // state registers; reset discards any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            first_q <= 1'b1;
            last_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            blk_q   <= '0;
            phase_q <= 1'b1;
            mode_q  <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            mode_q  <= mode;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;
    assign busy = state_q == LOAD || state_q == SHIFT;
endmodule

// File: tb/tb_meter_display.sv
// tb_meter_display: scoreboard bench for meter_display with REFRESH_DIV=4, BLINK_HALF=16
module tb_meter_display;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b01;
    logic [15:0] times = 16'd205;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, busy;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         len;
    } rec_t;

    rec_t q[$];
    int   bq[$];
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    meter_display #(.REFRESH_DIV(4), .BLINK_HALF(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .times(times),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rec(input logic [3:0] a, input logic [6:0] s, input int l);
        rec_t r;
        r.an = a;
        r.seg = s;
        r.len = l;
        q.push_back(r);
    endtask

    task automatic dig(input logic [15:0] bcd, input int d, input int l);
        logic [3:0] one;
        logic [3:0] nib;
        one = 4'b0001;
        nib = bcd[4*d +: 4];
        rec(~(one << d), seg_tab[nib], l);
    endtask

    task automatic blank_rec(input int l);
        rec(4'b1111, 7'b1111111, l);
    endtask

    task automatic sync(input logic [3:0] target);
        logic [3:0] p;
        bit ok;
        p = an;
        ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (an == target && p != target) ok = 1;
            p = an;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sync: an never entered %b within 80 cycles", target);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q.size() > 0 || bq.size() > 0); i++) @(negedge clk);
        checks++;
        if (q.size() > 0 || bq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d scan and %0d busy expectations left unmatched", q.size(), bq.size());
            q.delete();
            bq.delete();
        end
    endtask

    task automatic set_times(input logic [15:0] v);
        @(posedge clk);
        #1 times = v;
        bq.push_back(17);
        repeat (25) @(posedge clk);
    endtask

    task automatic steady_check(input logic [15:0] bcd);
        sync(4'b1110);
        @(posedge clk);
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 4; d++) dig(bcd, d, 4);
        drain();
    endtask

    // monitor: every time {an,seg} changes, the run that just ended is scored
    initial begin
        logic [10:0] prev;
        int run;
        rec_t r;
        prev = 11'h7ff;
        run = 0;
        forever begin
            @(negedge clk);
            if ({an, seg} !== prev) begin
                if (run > 0 && q.size() > 0) begin
                    r = q.pop_front();
                    check("scan_value", {21'd0, prev}, {21'd0, r.an, r.seg});
                    if (r.len > 0) check("scan_len", run, r.len);
                end
                prev = {an, seg};
                run = 1;
            end else run++;
        end
    end

    // monitor: each completed busy pulse is scored for its length
    initial begin
        int bc;
        int e;
        bc = 0;
        forever begin
            @(negedge clk);
            if (busy) bc++;
            else begin
                if (bc > 0 && bq.size() > 0) begin
                    e = bq.pop_front();
                    check("busy_len", bc, e);
                end
                bc = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_an", an, 4'b1111);
        check("reset_seg", seg, 7'b1111111);
        check("reset_dp", dp, 1'b1);
        check("reset_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bq.push_back(17);
        repeat (25) @(posedge clk);
        steady_check(16'h0205);
        set_times(16'd12000);
        steady_check(16'h9999);
        set_times(16'd150);
        steady_check(16'h0150);
        // 1 Hz blink aligned so each on-phase spans whole digit slots
        sync(4'b1110);
        repeat (3) @(posedge clk);
        #1 mode = 2'b11;
        dig(16'h0150, 0, 4); dig(16'h0150, 1, 4); dig(16'h0150, 2, 4); dig(16'h0150, 3, 4); dig(16'h0150, 0, 4);
        blank_rec(16);
        dig(16'h0150, 1, 4); dig(16'h0150, 2, 4); dig(16'h0150, 3, 4); dig(16'h0150, 0, 4);
        blank_rec(16);
        drain();
        // leave blink during an off-phase: lit on the very next cycle
        sync(4'b1111);
        repeat (3) @(posedge clk);
        #1 mode = 2'b01;
        blank_rec(4);
        dig(16'h0150, 2, 4);
        drain();
        set_times(16'd0);
        steady_check(16'h0000);
        // 2 Hz blink: 8 on / 8 off
        sync(4'b1110);
        repeat (3) @(posedge clk);
        #1 mode = 2'b10;
        dig(16'h0000, 0, 4); dig(16'h0000, 1, 4); dig(16'h0000, 2, 4);
        blank_rec(8);
        dig(16'h0000, 1, 4); dig(16'h0000, 2, 4);
        blank_rec(8);
        drain();
        // mode 00 blanks for as long as it is held
        @(posedge clk);
        #1 mode = 2'b01;
        repeat (10) @(posedge clk);
        #1 mode = 2'b00;
        repeat (2) @(posedge clk);
        blank_rec(40);
        repeat (38) @(posedge clk);
        #1 mode = 2'b01;
        drain();
        // new value arrives mid-conversion: two back-to-back conversions
        @(posedge clk);
        #1 times = 16'd10;
        bq.push_back(17);
        repeat (5) @(posedge clk);
        #1 times = 16'd205;
        bq.push_back(17);
        repeat (50) @(posedge clk);
        steady_check(16'h0205);
        // reset in the middle of a shift sequence
        @(posedge clk);
        #1 times = 16'd4321;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_an", an, 4'b1111);
        check("midreset_seg", seg, 7'b1111111);
        check("midreset_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bq.push_back(17);
        repeat (25) @(posedge clk);
        steady_check(16'h4321);
        check("final_dp", dp, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
